axis_escape_framer: RTL and testbench
=====================================

# axis_escape_framer

Parametrised AXI-Stream byte-stuffing escaper. It prefixes an escape symbol to every data word that collides with a reserved control symbol, and can optionally transform the escaped word. When built with frame delimiters, it also brackets every frame with start and end symbols. It sits between the packet source and the Manchester line encoder, replacing the fixed-width, fixed-symbol escaper.

## Interface
- DATA_WIDTH, 8: word width of both streams.
- ESCAPE_SYMBOL, 8'hE5: prefix word; itself reserved.
- START_SYMBOL, 8'hD5: start-of-frame word; reserved.
- END_SYMBOL, 8'hC5: end-of-frame word; reserved.
- ESC_XOR, 0: mask XORed into a reserved word emitted after ESCAPE_SYMBOL; 0 gives the legacy behaviour.
- aclk  in  1  sole clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  input word.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready; combinational from state and output-register occupancy.
- s_axis_tlast  in  1  last word of frame.
- m_axis_tdata  out  DATA_WIDTH  output word, registered.
- m_axis_tvalid  out  1  output valid, registered.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  frame end, registered.

## Operation
- Reserved set: {ESCAPE_SYMBOL, START_SYMBOL, END_SYMBOL}. This set applies regardless of the configuration macro.
- A beat is accepted only in S_PASS, and only when the output slot is free or draining (!m_axis_tvalid || m_axis_tready). The accepted word, its last flag and its esc flag are captured in a hold register.
- States:
  - S_PASS
    - If SOF is pending (macro on and !in_frame), emit START_SYMBOL, then go to S_ESC if esc, else S_DATA.
    - Else if esc, emit ESCAPE_SYMBOL and go to S_DATA.
    - Else emit the word directly. Stay in S_PASS, or go to S_EOF if last and the macro is on.
  - S_ESC: emit ESCAPE_SYMBOL, then go to S_DATA.
  - S_DATA
    - Emit the held word, XORed with ESC_XOR if esc.
    - Then go to S_EOF if last and the macro is on, else S_PASS.
  - S_EOF: emit END_SYMBOL with tlast=1, then go to S_PASS.
- Each emission loads the output register and advances state only when the slot is free or draining.
- in_frame:
  - Set on the first accepted beat of a frame.
  - Cleared when a beat with s_axis_tlast is accepted.
- Words that are not reserved pass unmodified. Delimiters are never escaped.
- ESC_XOR is applied only to the word following an inserted ESCAPE_SYMBOL.

## Timing
- Reset (asynchronous, immediate):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready=0 while aresetn is low.
  - State S_PASS, in_frame=0, hold register cleared.
  - A held word is discarded.
- s_axis_tready=1 is first possible on the first rising edge after release.
- Latency: input handshake at edge N puts the first output word valid after edge N (1 cycle).
- Throughput:
  - Unreserved word: 1 cycle.
  - Escaped word: 2 cycles.
  - +1 cycle each for SOF and EOF when enabled.
  - s_axis_tready is low in S_ESC, S_DATA and S_EOF.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast are held stable. No state advances.
- Simultaneous drain and load: a new word is loaded on the same edge the old one is consumed (no bubble).
- A tlast on a reserved word lands on the transformed data word (macro off) or on END_SYMBOL (macro on); never on ESCAPE_SYMBOL.
- A single-word frame with the macro on produces 3 or 4 output words. in_frame clears on the accept edge.

## Configuration
- ESC_FRAME_DELIM_EN
  - Defined:
    - START_SYMBOL is inserted before the first word of each frame.
    - END_SYMBOL with m_axis_tlast=1 is inserted after the tlast word.
    - Data words never carry tlast.
  - Undefined:
    - S_EOF, in_frame and SOF insertion are compiled out.
    - tlast is passed through on the last emitted word of the input beat.

## Structure
- Shared package escape_pkg:
  - state enum (S_PASS, S_ESC, S_DATA, S_EOF).
  - default symbol constants E5/D5/C5.
- One sub-module, escape_match: combinational reserved-set comparator, parametrised by DATA_WIDTH and the three symbols.
- The FSM, hold register and output register are in the top module.

## Test plan
- Macro off, ESC_XOR=0, tready=1. Input D5,11,22,33,E5[last],44 → output E5,D5,11,22,33,E5,E5[tlast],44.
- Back-to-back input 11,12,13,14, tready=1 → one output per cycle, first one cycle after accept, s_axis_tready stays 1.
- Input E5 with m_axis_tready low for 5 cycles mid-sequence → E5 held stable, s_axis_tready=0, then E5,E5 delivered with no loss or duplication.
- ESC_XOR=8'h20, input D5,C5 → E5,F5,E5,E5.
- Macro on:
  - Frame 11,C5[last] → D5,11,E5,C5,C5[tlast].
  - Next frame 22[last] → D5,22,C5[tlast].
- Reset asserted in S_DATA with held E5 → m_axis_tvalid=0 immediately. After release, input 33 → output 33 only (plus D5 first when the macro is on).

Source files
------------

// File: rtl/escape_pkg.sv
// Shared types and default symbols for the AXI-Stream byte-stuffing escaper.
package escape_pkg;

  // Framer FSM states; S_EOF is only reachable when frame delimiters are built in.
  typedef enum logic [1:0] {
    S_PASS = 2'd0,
    S_ESC  = 2'd1,
    S_DATA = 2'd2,
    S_EOF  = 2'd3
  } state_e;

  localparam logic [7:0] ESC_SYMBOL_DEFAULT   = 8'hE5;
  localparam logic [7:0] START_SYMBOL_DEFAULT = 8'hD5;
  localparam logic [7:0] END_SYMBOL_DEFAULT   = 8'hC5;

endpackage

// File: rtl/escape_match.sv
// Combinational comparator: flags a word that collides with any reserved symbol.
module escape_match
  import escape_pkg::*;
#(
  parameter int unsigned              DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0]    ESCAPE_SYMBOL = DATA_WIDTH'(ESC_SYMBOL_DEFAULT),
  parameter logic [DATA_WIDTH-1:0]    START_SYMBOL  = DATA_WIDTH'(START_SYMBOL_DEFAULT),
  parameter logic [DATA_WIDTH-1:0]    END_SYMBOL    = DATA_WIDTH'(END_SYMBOL_DEFAULT)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  hit
);

  // The reserved set is the same whether or not delimiters are inserted.
  always_comb begin
    hit = (data == ESCAPE_SYMBOL) || (data == START_SYMBOL) || (data == END_SYMBOL);
  end

endmodule

// File: rtl/axis_escape_framer.sv
// AXI-Stream byte-stuffing escaper with optional frame delimiters.
// Build option: define ESC_FRAME_DELIM_EN to bracket each frame with START/END symbols.
module axis_escape_framer
  import escape_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] ESCAPE_SYMBOL = DATA_WIDTH'(ESC_SYMBOL_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] START_SYMBOL  = DATA_WIDTH'(START_SYMBOL_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] END_SYMBOL    = DATA_WIDTH'(END_SYMBOL_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] ESC_XOR       = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  state_e                  state, state_next;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    hold_last;
  logic                    hold_esc;
  logic                    in_esc;
  logic                    slot_free;
  logic                    accept;
  logic                    ready_en;
  logic                    sof_pending;
  logic                    delim_en;
  logic                    emit_valid;
  logic [DATA_WIDTH-1:0]   emit_data;
  logic                    emit_last;

  escape_match #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ESCAPE_SYMBOL(ESCAPE_SYMBOL),
    .START_SYMBOL (START_SYMBOL),
    .END_SYMBOL   (END_SYMBOL)
  ) u_match (
    .data(s_axis_tdata),
    .hit (in_esc)
  );

  // Output slot can take a new word when empty or being consumed this edge.
  assign slot_free     = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = ready_en && (state == S_PASS) && slot_free;
  assign accept        = s_axis_tvalid && s_axis_tready;

`ifdef ESC_FRAME_DELIM_EN
  logic in_frame;

  assign delim_en    = 1'b1;
  assign sof_pending = !in_frame;

  // Track whether the next accepted beat opens a new frame.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_frame <= 1'b0;
    end else if (accept) begin
      in_frame <= !s_axis_tlast;
    end
  end
`else
  assign delim_en    = 1'b0;
  assign sof_pending = 1'b0;
`endif

  // Keep the input ready low until the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Capture the accepted beat for the follow-up emissions.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_esc  <= 1'b0;
    end else if (accept) begin
      hold_data <= s_axis_tdata;
      hold_last <= s_axis_tlast;
      hold_esc  <= in_esc;
    end
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_PASS;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: states only advance when the output slot accepts the emission.
  always_comb begin
    state_next = state;
    unique case (state)
      S_PASS: begin
        if (accept) begin
          if (sof_pending) begin
            state_next = in_esc ? S_ESC : S_DATA;
          end else if (in_esc) begin
            state_next = S_DATA;
          end else if (s_axis_tlast && delim_en) begin
            state_next = S_EOF;
          end
        end
      end
      S_ESC: begin
        if (slot_free) state_next = S_DATA;
      end
      S_DATA: begin
        if (slot_free) state_next = (hold_last && delim_en) ? S_EOF : S_PASS;
      end
`ifdef ESC_FRAME_DELIM_EN
      S_EOF: begin
        if (slot_free) state_next = S_PASS;
      end
`endif
      default: state_next = S_PASS;
    endcase
  end

  // FSM output: the word to load into the output register this cycle.
  always_comb begin
    emit_valid = 1'b0;
    emit_data  = '0;
    emit_last  = 1'b0;
    unique case (state)
      S_PASS: begin
        if (accept) begin
          emit_valid = 1'b1;
          if (sof_pending) begin
            emit_data = START_SYMBOL;
          end else if (in_esc) begin
            emit_data = ESCAPE_SYMBOL;
          end else begin
            emit_data = s_axis_tdata;
            emit_last = s_axis_tlast && !delim_en;
          end
        end
      end
      S_ESC: begin
        emit_valid = 1'b1;
        emit_data  = ESCAPE_SYMBOL;
      end
      S_DATA: begin
        emit_valid = 1'b1;
        emit_data  = hold_esc ? (hold_data ^ ESC_XOR) : hold_data;
        emit_last  = hold_last && !delim_en;
      end
`ifdef ESC_FRAME_DELIM_EN
      S_EOF: begin
        emit_valid = 1'b1;
        emit_data  = END_SYMBOL;
        emit_last  = 1'b1;
      end
`endif
      default: begin
        emit_valid = 1'b0;
      end
    endcase
  end

  // Output register: load on a free or draining slot, hold while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (slot_free) begin
      m_axis_tvalid <= emit_valid;
      if (emit_valid) begin
        m_axis_tdata <= emit_data;
        m_axis_tlast <= emit_last;
      end
    end
  end

endmodule

// File: tb/tb_axis_escape_framer.sv
// Self-checking bench: two framers (ESC_XOR 0 and 8'h20) share one input stream and
// are compared word by word against a frame-level reference model.
module tb_axis_escape_framer;

`ifdef ESC_FRAME_DELIM_EN
  localparam bit Delim = 1'b1;
`else
  localparam bit Delim = 1'b0;
`endif

  logic       clk;
  logic       aresetn;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       m_tready;
  logic       s_tready_w [2];
  logic [7:0] m_tdata_w  [2];
  logic       m_tvalid_w [2];
  logic       m_tlast_w  [2];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  bit          mdl_in_frame = 1'b0;
  logic [8:0]  exp_q0[$];
  logic [8:0]  exp_q1[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_escape_framer #(
      .DATA_WIDTH(8),
      .ESC_XOR   ((g == 0) ? 8'h00 : 8'h20)
    ) u_dut (
      .aclk         (clk),
      .aresetn      (aresetn),
      .s_axis_tdata (s_tdata),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready_w[g]),
      .s_axis_tlast (s_tlast),
      .m_axis_tdata (m_tdata_w[g]),
      .m_axis_tvalid(m_tvalid_w[g]),
      .m_axis_tready(m_tready),
      .m_axis_tlast (m_tlast_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic flag_fail(input string tag);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", tag);
  endtask

  // Reference model: expand one input beat into the words the stream must carry.
  function automatic void model_beat(input logic [7:0] d, input bit last);
    bit rsv;
    bit dl;
    rsv = (d == 8'hE5) || (d == 8'hD5) || (d == 8'hC5);
    dl  = Delim ? 1'b0 : last;
    if (Delim && !mdl_in_frame) begin
      exp_q0.push_back(9'h0D5);
      exp_q1.push_back(9'h0D5);
    end
    if (rsv) begin
      exp_q0.push_back(9'h0E5);
      exp_q1.push_back(9'h0E5);
      exp_q0.push_back({dl, d});
      exp_q1.push_back({dl, d ^ 8'h20});
    end else begin
      exp_q0.push_back({dl, d});
      exp_q1.push_back({dl, d});
    end
    if (Delim && last) begin
      exp_q0.push_back(9'h1C5);
      exp_q1.push_back(9'h1C5);
    end
    mdl_in_frame = !last;
  endfunction

  // Downstream ready, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(0, 9) < 7);
      default: m_tready = 1'b0;
    endcase
  end

  // Output monitor: every transferred word must match the model's next word.
  always @(negedge clk) begin
    if (aresetn) begin
      if (m_tvalid_w[0] && m_tready) begin
        if (exp_q0.size() == 0) flag_fail("out0_extra_word");
        else check_eq("out0_word", {23'd0, m_tlast_w[0], m_tdata_w[0]}, {23'd0, exp_q0.pop_front()});
      end
      if (m_tvalid_w[1] && m_tready) begin
        if (exp_q1.size() == 0) flag_fail("out1_extra_word");
        else check_eq("out1_word", {23'd0, m_tlast_w[1], m_tdata_w[1]}, {23'd0, exp_q1.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one beat; called and returns at 2 time units after a rising edge.
  task automatic send(input logic [7:0] d, input bit last, input bit want_ready);
    bit done;
    done     = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (want_ready && n == 0) check_eq("b2b_s_tready", {31'd0, s_tready_w[0]}, 32'd1);
      if (s_tready_w[0]) begin
        model_beat(d, last);
        done = 1'b1;
      end
      tick();
      if (done) begin
        check_eq("accept_latency", {31'd0, m_tvalid_w[0]}, 32'd1);
        break;
      end
    end
    if (!done) flag_fail("send_timeout");
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && !m_tvalid_w[0] && !m_tvalid_w[1]) begin
        idle = 1'b1;
        break;
      end
      tick();
    end
    if (!idle) flag_fail("drain_timeout");
  endtask

  initial begin
    logic [7:0] seq_a [6];
    logic [7:0] rsv_tab [3];
    seq_a   = '{8'hD5, 8'h11, 8'h22, 8'h33, 8'hE5, 8'h44};
    rsv_tab = '{8'hE5, 8'hD5, 8'hC5};
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    rdy_mode = 0;

    // Reset values while held in reset.
    repeat (3) @(posedge clk);
    #3;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_m_tvalid", {31'd0, m_tvalid_w[i]}, 32'd0);
      check_eq("rst_m_tdata", {24'd0, m_tdata_w[i]}, 32'd0);
      check_eq("rst_m_tlast", {31'd0, m_tlast_w[i]}, 32'd0);
      check_eq("rst_s_tready", {31'd0, s_tready_w[i]}, 32'd0);
    end
    @(posedge clk);
    #4;
    aresetn = 1'b1;
    #1;
    check_eq("rdy_before_first_edge", {31'd0, s_tready_w[0]}, 32'd0);
    tick();
    check_eq("rdy_after_first_edge", {31'd0, s_tready_w[0]}, 32'd1);

    // Mixed reserved / plain words, one tlast on a reserved word.
    for (int i = 0; i < 6; i++) send(seq_a[i], (i == 4), 1'b0);
    wait_drain();

    // Back-to-back plain words at full rate.
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b0, !Delim);
    wait_drain();

    // XOR transform path on reserved words.
    send(8'hD5, 1'b0, 1'b0);
    send(8'hC5, 1'b1, 1'b0);
    wait_drain();

    // Frame shapes for the delimiter build: two-word and single-word frames.
    send(8'h11, 1'b0, 1'b0);
    send(8'hC5, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    wait_drain();

    // Downstream stall with a reserved word in flight.
    rdy_mode = 2;
    tick();
    send(8'hE5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_m_tvalid", {31'd0, m_tvalid_w[0]}, 32'd1);
      check_eq("stall_m_tdata", {24'd0, m_tdata_w[0]},
               {24'd0, (exp_q0.size() > 0) ? exp_q0[0][7:0] : 8'hXX});
      check_eq("stall_s_tready", {31'd0, s_tready_w[0]}, 32'd0);
      tick();
    end
    rdy_mode = 0;
    wait_drain();

    // Asynchronous reset while a reserved word is held mid-escape.
    rdy_mode = 2;
    tick();
    send(8'hE5, 1'b1, 1'b0);
    #1;
    aresetn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("midrst_m_tvalid", {31'd0, m_tvalid_w[i]}, 32'd0);
      check_eq("midrst_m_tdata", {24'd0, m_tdata_w[i]}, 32'd0);
      check_eq("midrst_s_tready", {31'd0, s_tready_w[i]}, 32'd0);
    end
    exp_q0.delete();
    exp_q1.delete();
    mdl_in_frame = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #4;
    aresetn = 1'b1;
    tick();
    send(8'h33, 1'b1, 1'b0);
    wait_drain();

    // Randomized traffic with random backpressure, biased toward reserved words.
    rdy_mode = 1;
    for (int b = 0; b < 300; b++) begin
      logic [7:0] d;
      bit         last;
      if ($urandom_range(0, 3) == 0) d = rsv_tab[$urandom_range(0, 2)];
      else d = 8'($urandom);
      last = ($urandom_range(0, 4) == 0);
      send(d, last, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    rdy_mode = 0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
